// File: rtl/decode_stage_pipe.sv
// RV32 decode stage: register file with write-back bypass, control/immediate
// decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              instruction,
    input  logic [XLEN-1:0]          pc,
    input  logic                     wb_we,
    input  logic [$clog2(NREG)-1:0]  wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     ex_stall,
    input  logic                     flush,
    output logic                     pc_load,
    output logic                     if_id_load,
    output logic                     out_valid,
    output logic                     out_mem_re,
    output logic                     out_mem_we,
    output logic                     out_reg_write,
    output logic                     out_branch,
    output logic                     out_alu_src,
    output logic [1:0]               out_alu_op,
    output logic [XLEN-1:0]          out_rs1_data,
    output logic [XLEN-1:0]          out_rs2_data,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(NREG)-1:0]  out_rd,
    output logic [$clog2(NREG)-1:0]  out_rs1,
    output logic [$clog2(NREG)-1:0]  out_rs2,
    output logic [9:0]               out_funct,
    output logic [15:0]              stall_count
);
    localparam int AW = $clog2(NREG);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_LOAD_USE
    } action_t;

    typedef struct packed {
        logic            valid;
        logic            mem_re;
        logic            mem_we;
        logic            reg_write;
        logic            branch;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [9:0]      funct;
    } idex_t;

    logic [XLEN-1:0] regs [NREG];
    logic [6:0]      opcode;
    logic [AW-1:0]   rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            use_rs1, use_rs2, hazard;
    action_t         action;
    idex_t           idex_d, idex_q;

    assign opcode = instruction[6:0];
    assign rd_f   = instruction[7 +: AW];
    assign rs1_f  = instruction[15 +: AW];
    assign rs2_f  = instruction[20 +: AW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Bypass lets an instruction see a value being written back this cycle.
    always_comb begin
        rs1_val = regs[rs1_f];
        rs2_val = regs[rs2_f];
        if (WB_BYPASS && wb_we && wb_rd == rs1_f) rs1_val = wb_data;
        if (WB_BYPASS && wb_we && wb_rd == rs2_f) rs2_val = wb_data;
        if (rs1_f == '0) rs1_val = '0;
        if (rs2_f == '0) rs2_val = '0;
    end

    always_comb begin
        idex_d          = '0;
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        idex_d.valid    = 1'b1;
        idex_d.rs1_data = rs1_val;
        idex_d.rs2_data = rs2_val;
        idex_d.pc       = pc;
        idex_d.rd       = rd_f;
        idex_d.rs1      = rs1_f;
        idex_d.rs2      = rs2_f;
        idex_d.funct    = {instruction[31:25], instruction[14:12]};
        unique case (opcode)
            OP_R: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_op    = 2'b10;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_IALU: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_src   = 1'b1;
                idex_d.alu_op    = 2'b10;
                idex_d.imm       = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
                use_rs1          = 1'b1;
            end
            OP_LOAD: begin
                idex_d.mem_re    = 1'b1;
                idex_d.reg_write = 1'b1;
                idex_d.alu_src   = 1'b1;
                idex_d.imm       = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
                use_rs1          = 1'b1;
            end
            OP_STORE: begin
                idex_d.mem_we    = 1'b1;
                idex_d.alu_src   = 1'b1;
                idex_d.imm       = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                                    instruction[11:7]};
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                idex_d.branch    = 1'b1;
                idex_d.alu_op    = 2'b01;
                idex_d.imm       = {{(XLEN-13){instruction[31]}}, instruction[31],
                                    instruction[7], instruction[30:25],
                                    instruction[11:8], 1'b0};
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            default: ;
        endcase
    end

    assign hazard = idex_q.valid && idex_q.mem_re && idex_q.rd != '0 && in_valid &&
                    ((use_rs1 && idex_q.rd == rs1_f) || (use_rs2 && idex_q.rd == rs2_f));

    always_comb begin
        action = ACT_NORMAL;
        if (flush)         action = ACT_FLUSH;
        else if (ex_stall) action = ACT_HOLD;
        else if (hazard)   action = ACT_LOAD_USE;
    end

    assign pc_load    = !reset || action == ACT_NORMAL || action == ACT_FLUSH;
    assign if_id_load = pc_load;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            unique case (action)
                ACT_FLUSH, ACT_LOAD_USE: idex_q <= '0;
                ACT_HOLD:                idex_q <= idex_q;
                default:                 idex_q <= in_valid ? idex_d : '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (action == ACT_LOAD_USE && stall_count != '1) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign out_valid     = idex_q.valid;
    assign out_mem_re    = idex_q.mem_re;
    assign out_mem_we    = idex_q.mem_we;
    assign out_reg_write = idex_q.reg_write;
    assign out_branch    = idex_q.branch;
    assign out_alu_src   = idex_q.alu_src;
    assign out_alu_op    = idex_q.alu_op;
    assign out_rs1_data  = idex_q.rs1_data;
    assign out_rs2_data  = idex_q.rs2_data;
    assign out_imm       = idex_q.imm;
    assign out_pc        = idex_q.pc;
    assign out_rd        = idex_q.rd;
    assign out_rs1       = idex_q.rs1;
    assign out_rs2       = idex_q.rs2;
    assign out_funct     = idex_q.funct;
endmodule
